// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: data-memory bus between the access unit (master) and memory (slave).
interface mem_access_unit_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        ack;
    logic [31:0] rdata;
    modport master (output req, we, addr, wdata, be, input ack, rdata);
    modport slave  (input req, we, addr, wdata, be, output ack, rdata);
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store sequencer with alignment check, lane steering,
// load formatting, pipeline stall and bus timeout.
module mem_access_unit #(
    parameter int DATA_WIDTH  = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic                  i_regWrite,
    input  logic                  i_memRead,
    input  logic                  i_memWrite,
    input  logic                  i_memToReg,
    input  logic [1:0]            i_dataSize,
    input  logic [2:0]            i_func3,
    input  logic [DATA_WIDTH-1:0] i_alu,
    input  logic [DATA_WIDTH-1:0] i_data2,
    input  logic [4:0]            i_rd_addr,
    mem_access_unit_if.master     dmem,
    output logic                  o_stall,
    output logic                  o_regWrite,
    output logic                  o_memToReg,
    output logic [4:0]            o_rd_addr,
    output logic [DATA_WIDTH-1:0] o_alu,
    output logic [DATA_WIDTH-1:0] o_load_data,
    output logic                  o_misalign,
    output logic                  o_bus_err
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t          r_state;
    logic            r_req, r_we, r_bus_err;
    logic [31:0]     r_addr, r_wdata, r_load;
    logic [3:0]      r_be;
    logic [1:0]      r_off;
    logic [2:0]      r_func3;
    logic [CW-1:0]   r_cnt;
    logic            w_access, w_aligned, w_op, w_mis;
    logic [3:0]      w_be;
    logic [31:0]     w_wdata, w_shift, w_load;
    assign w_access  = i_memRead | i_memWrite;
    assign w_aligned = (i_dataSize == 2'b00) | (i_dataSize == 2'b01 & ~i_alu[0]) |
                       (i_dataSize == 2'b10 & i_alu[1:0] == 2'b00);
    assign w_op      = (r_state == IDLE) & w_access & w_aligned;
    assign w_mis     = (r_state == IDLE) & w_access & ~w_aligned;
    assign w_be      = ~i_memWrite ? 4'hf :
                       i_dataSize == 2'b00 ? 4'b0001 << i_alu[1:0] :
                       i_dataSize == 2'b01 ? 4'b0011 << i_alu[1:0] : 4'hf;
    assign w_wdata   = i_dataSize == 2'b00 ? {4{i_data2[7:0]}} :
                       i_dataSize == 2'b01 ? {2{i_data2[15:0]}} : i_data2;
    // Shift the addressed lane down to bit 0, then extend by func3[2].
    assign w_shift   = dmem.rdata >> {r_off, 3'b000};
    assign w_load    = r_func3[1:0] == 2'b00 ? {{24{~r_func3[2] & w_shift[7]}}, w_shift[7:0]} :
                       r_func3[1:0] == 2'b01 ? {{16{~r_func3[2] & w_shift[15]}}, w_shift[15:0]} :
                       dmem.rdata;
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_bus_err <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_load    <= '0;
            r_be      <= '0;
            r_off     <= '0;
            r_func3   <= '0;
            r_cnt     <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_op) begin
                    r_state <= BUSY;
                    r_req   <= 1'b1;
                    r_we    <= i_memWrite;
                    r_addr  <= {i_alu[31:2], 2'b00};
                    r_be    <= w_be;
                    r_wdata <= w_wdata;
                    r_off   <= i_alu[1:0];
                    r_func3 <= i_func3;
                    r_cnt   <= '0;
                end
                BUSY: if (dmem.ack) begin
                    r_req   <= 1'b0;
                    r_state <= DONE;
                    if (!r_we) r_load <= w_load;
                end else if (r_cnt == CW'(TIMEOUT_CYC - 1)) begin
                    r_req     <= 1'b0;
                    r_bus_err <= 1'b1;
                    r_state   <= DONE;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                DONE: begin
                    r_state   <= IDLE;
                    r_bus_err <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign dmem.req    = r_req;
    assign dmem.we     = r_we;
    assign dmem.addr   = r_addr;
    assign dmem.wdata  = r_wdata;
    assign dmem.be     = r_be;
    assign o_stall     = w_op | (r_state == BUSY);
    // r_bus_err is only ever set during DONE, so it also marks a timed-out DONE.
    assign o_regWrite  = i_regWrite & ~o_stall & ~w_mis & ~r_bus_err;
    assign o_memToReg  = i_memToReg;
    assign o_rd_addr   = i_rd_addr;
    assign o_alu       = i_alu;
    assign o_load_data = r_load;
    assign o_misalign  = w_mis;
    assign o_bus_err   = r_bus_err;
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, 32, datapath width; only 32 is supported (4 byte lanes).
REQ-002 SHALL have parameter TIMEOUT_CYC, 255, maximum BUSY cycles waiting for i_dmem_ack.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 i_rst  input  1  asynchronous, active-high reset.
REQ-005 i_regWrite, i_memRead, i_memWrite, i_memToReg  input  1 each  controls from EX/MEM.
REQ-006 i_dataSize  input  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
REQ-007 i_func3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-008 i_alu  input  32  effective address or ALU result; i_data2  input  32  store data; i_rd_addr  input  5  destination register.
REQ-009 o_dmem_req  output  1  bus request; o_dmem_we  output  1  write strobe; o_dmem_addr  output  32  word-aligned address; o_dmem_wdata  output  32  lane-replicated write data; o_dmem_be  output  4  byte enables.
REQ-010 i_dmem_ack  input  1  one-cycle completion; i_dmem_rdata  input  32  read data, valid with ack.
REQ-011 o_stall  output  1  hold EX/MEM and upstream stages (drives their enable low).
REQ-012 o_regWrite, o_memToReg  output  1  o_rd_addr  output  5  o_alu  output  32  o_load_data  output  32  results to MEM/WB.
REQ-013 o_misalign, o_bus_err  output  1  one-cycle fault pulses.

Function
REQ-014 FSM states SHALL be IDLE, BUSY, DONE.
REQ-015 Memory op = (i_memRead|i_memWrite) and aligned; when both are high, i_memWrite takes precedence.
REQ-016 Aligned: byte always; half when i_alu[0]=0; word when i_alu[1:0]=00; size 11 is never aligned.
REQ-017 IDLE + memory op: o_stall=1 combinationally; at the edge, register addr={i_alu[31:2],2'b00}, we, be, wdata; set o_dmem_req=1; go to BUSY.
REQ-018 Byte enables: byte 0001<<i_alu[1:0]; half 0011<<i_alu[1:0]; word 1111; all reads use 1111.
REQ-019 Write data: byte i_data2[7:0] replicated x4; half i_data2[15:0] replicated x2; word i_data2.
REQ-020 BUSY: o_stall=1; o_dmem_req, addr, we, be, and wdata held stable until the ack edge.
REQ-021 BUSY + i_dmem_ack: deassert req; for reads, register formatted o_load_data; go to DONE.
REQ-022 Load formatting: select the lane(s) by registered addr[1:0]; func3[2]=0 sign-extends, func3[2]=1 zero-extends; LW passes the word through.
REQ-023 Timeout counter SHALL clear on BUSY entry and increment each BUSY cycle without ack; reaching TIMEOUT_CYC deasserts req, pulses o_bus_err, and goes to DONE.
REQ-024 DONE: o_stall=0 for one cycle; return to IDLE next edge with no re-trigger, since EX/MEM loads the next instruction on that edge.
REQ-025 Minimum memory op: 3 cycles (IDLE, BUSY with ack, DONE), i.e. 2 stall cycles.
REQ-026 i_dmem_ack outside BUSY SHALL be ignored.
REQ-027 o_alu, o_rd_addr, and o_memToReg pass through combinationally from inputs.
REQ-028 o_regWrite = i_regWrite & ~o_stall & ~(misaligned op in IDLE) & ~(DONE after timeout).
REQ-029 Misaligned op in IDLE: no request, no stall, o_misalign=1 that cycle, state stays IDLE.
REQ-030 A non-memory op in IDLE passes through with o_stall=0.

Reset
REQ-031 i_rst asserted SHALL immediately clear state to IDLE and clear o_dmem_req, o_dmem_we, o_dmem_be, o_dmem_addr, o_dmem_wdata, o_load_data, timeout counter, and the fault flags to 0.
REQ-032 Reset in BUSY SHALL abandon the access; a late ack after reset is ignored.

Verification
REQ-033 LB at 0x103, rdata=0x80FF_FF00, ack in first BUSY cycle -> addr 0x100, be 1111, o_load_data 0xFFFF_FF80, o_stall high 2 cycles.
REQ-034 SH of data2=0x1234_ABCD at 0x202 -> be 1100, wdata 0xABCD_ABCD, we=1, o_regWrite=0 throughout.
REQ-035 LW at 0x006 -> o_misalign pulse, o_dmem_req never asserts, o_stall=0, o_regWrite=0.
REQ-036 LHU at 0x010, ack after 5 BUSY cycles, rdata=0x0000_8001 -> o_load_data 0x0000_8001; req, addr, and be are stable for all 5 cycles.
REQ-037 TIMEOUT_CYC=4, no ack -> o_bus_err pulse after 4 BUSY cycles, then DONE, then IDLE, o_regWrite suppressed.
REQ-038 i_rst asserted mid-BUSY, then ack 1 cycle later -> o_dmem_req drops immediately, state IDLE, ack ignored.
